pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage pipeline (IF_ID, ID_EX, EX_MEM, MEM_WB regs).

---
 rtl/hazard_pkg.sv | 24 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/hazard_perf_cnt.sv | 30 +++
 rtl/pipe_hazard_ctrl.sv | 132 +++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types for the pipeline hazard controller
package hazard_pkg;

  localparam int REG_W_DEF = 4;

  typedef enum logic [1:0] {
    RUN  = 2'd0,
    MEMW = 2'd1,
    SKIP = 2'd2
  } hz_state_e;

  typedef struct packed {
    logic stall_pc;
    logic stall_if_id;
    logic stall_id_ex;
    logic stall_ex_mem;
    logic flush_if_id;
    logic flush_id_ex;
    logic flush_mem_wb;
  } hz_ctrl_t;

  localparam hz_ctrl_t HZ_CTRL_IDLE = '0;

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - pipeline <-> hazard controller signal bundle
interface pipe_hazard_ctrl_if #(
  parameter int REG_W = hazard_pkg::REG_W_DEF
);

  logic [REG_W-1:0] id_rs1;
  logic [REG_W-1:0] id_rs2;
  logic             id_rs1_used;
  logic             id_rs2_used;
  logic [REG_W-1:0] ex_reg_dst;
  logic             ex_reg_wr;
  logic             ex_mem_rd;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ack;

  logic stall_pc;
  logic stall_if_id;
  logic stall_id_ex;
  logic stall_ex_mem;
  logic flush_if_id;
  logic flush_id_ex;
  logic flush_mem_wb;
  logic mem_err;
  logic busy;

  modport master (
    output id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_mem_rd, ex_br_taken, mem_req, mem_ack,
    input  stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb, mem_err, busy
  );

  modport slave (
    input  id_rs1, id_rs2, id_rs1_used, id_rs2_used, ex_reg_dst, ex_reg_wr,
           ex_mem_rd, ex_br_taken, mem_req, mem_ack,
    output stall_pc, stall_if_id, stall_id_ex, stall_ex_mem,
           flush_if_id, flush_id_ex, flush_mem_wb, mem_err, busy
  );

endinterface

// File: rtl/hazard_perf_cnt.sv
// rtl/hazard_perf_cnt.sv - saturating stall/flush/timeout event counters
module hazard_perf_cnt #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc_stall,
  input  logic             inc_flush,
  input  logic             inc_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] timeout_events
);

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cycles   <= '0;
      flush_events   <= '0;
      timeout_events <= '0;
    end else begin
      if (inc_stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 1'b1;
      if (inc_flush && (flush_events != '1))
        flush_events <= flush_events + 1'b1;
      if (inc_timeout && (timeout_events != '1))
        timeout_events <= timeout_events + 1'b1;
    end
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - stall/flush sequencer with memory-wait timeout
// Optional perf counters enabled by defining HAZARD_PERF_CNT_EN.
module pipe_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int REG_W       = REG_W_DEF,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_ctrl_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events,
  output logic [CNT_W-1:0] timeout_events
`endif
);

  localparam int TMR_W = $clog2(MEM_TIMEOUT + 1);

  if (MEM_TIMEOUT < 2 || CNT_W < 1 || REG_W < 1) begin : g_bad_param
    $error("pipe_hazard_ctrl: invalid parameter set");
  end

  hz_state_e        state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             err_q, err_d;
  hz_ctrl_t         ctrl;
  logic             mem_wait;
  logic             load_use;
  logic [REG_W-1:0] dst;

  assign dst      = hz.ex_reg_dst;
  assign mem_wait = hz.mem_req & ~hz.mem_ack & (state_q != SKIP);
  assign load_use = hz.ex_mem_rd & hz.ex_reg_wr & (dst != '0) &
                    ((hz.id_rs1_used & (hz.id_rs1 == dst)) |
                     (hz.id_rs2_used & (hz.id_rs2 == dst)));

  // Priority mux; everything is forced idle while reset is held.
  always_comb begin
    ctrl = HZ_CTRL_IDLE;
    if (!rst) begin
      if (mem_wait) begin
        ctrl.stall_pc     = 1'b1;
        ctrl.stall_if_id  = 1'b1;
        ctrl.stall_id_ex  = 1'b1;
        ctrl.stall_ex_mem = 1'b1;
        ctrl.flush_mem_wb = 1'b1;
      end else if (hz.ex_br_taken) begin
        ctrl.flush_if_id  = 1'b1;
        ctrl.flush_id_ex  = 1'b1;
      end else if (load_use) begin
        ctrl.stall_pc     = 1'b1;
        ctrl.stall_if_id  = 1'b1;
        ctrl.flush_id_ex  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    err_d   = err_q;
    unique case (state_q)
      RUN: begin
        if (mem_wait) begin
          state_d = MEMW;
          timer_d = TMR_W'(1);
        end
      end
      MEMW: begin
        if (!mem_wait) begin
          state_d = RUN;
          timer_d = '0;
        end else if (timer_q == TMR_W'(MEM_TIMEOUT - 1)) begin
          state_d = SKIP;
          timer_d = '0;
          err_d   = 1'b1;
        end else if (timer_q != '1) begin
          timer_d = timer_q + 1'b1;
        end
      end
      // The stalled access is abandoned: one free cycle, then normal operation.
      SKIP: begin
        state_d = RUN;
        timer_d = '0;
      end
      default: begin
        state_d = RUN;
        timer_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      timer_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      err_q   <= err_d;
    end
  end

  assign hz.stall_pc     = ctrl.stall_pc;
  assign hz.stall_if_id  = ctrl.stall_if_id;
  assign hz.stall_id_ex  = ctrl.stall_id_ex;
  assign hz.stall_ex_mem = ctrl.stall_ex_mem;
  assign hz.flush_if_id  = ctrl.flush_if_id;
  assign hz.flush_id_ex  = ctrl.flush_id_ex;
  assign hz.flush_mem_wb = ctrl.flush_mem_wb;
  assign hz.mem_err      = err_q & ~rst;
  assign hz.busy         = (state_q != RUN) & ~rst;

`ifdef HAZARD_PERF_CNT_EN
  hazard_perf_cnt #(.CNT_W(CNT_W)) u_perf (
    .clk            (clk),
    .rst            (rst),
    .inc_stall      (ctrl.stall_pc),
    .inc_flush      (ctrl.flush_if_id | ctrl.flush_id_ex),
    .inc_timeout    ((state_q == MEMW) && (state_d == SKIP)),
    .stall_cycles   (stall_cycles),
    .flush_events   (flush_events),
    .timeout_events (timeout_events)
  );
`endif

endmodule
